// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Execute-stage load/store engine. Accepts a decoded load/store (is_LS,
// dec_lsign) together with the ALU effective address. It drives a
// request/grant/response data-memory port with aligned byte enables and
// lane-replicated store data. Load data is extracted and zero/sign-extended
// into lsu_rdata. lsu_busy freezes the pipeline while an access is in flight.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   : misaligned half/word accesses never reach
//                                      memory and complete with lsu_misalign=1.
//                         undefined : lsu_misalign is tied low. The low address
//                                      bits are force-aligned to the access size.
//
// Ports:
//   CLK, RSTN              clock (rising edge), async active-low reset
//   is_LS[3:0]             {enable, store, size[1:0]}  size: 11 W, 10 H, 01 B
//   dec_lsign              sign-extend byte/half loads
//   ls_addr, ls_wdata      effective address, store data (rs2)
//   lsu_flush              kill current/pending access
//   dmem_req/we/addr/be/wdata   memory request (held stable until grant)
//   dmem_gnt               request accepted this cycle
//   dmem_rvld, dmem_rdata  load response
//   lsu_busy               pipeline freeze request (combinational)
//   lsu_done               one-cycle completion pulse
//   lsu_rdata              extended load result (held until the next load)
//   lsu_misalign           misaligned access flag, valid with lsu_done
// -----------------------------------------------------------------------------
module load_store_unit (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic [3:0]  is_LS,
   input  logic        dec_lsign,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic        lsu_flush,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvld,
   input  logic [31:0] dmem_rdata,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_misalign
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;

   state_t      state_q, state_d;
   logic        start;
   logic        acc_misalign;
   logic [1:0]  off_eff;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [1:0]  size_q;
   logic        sign_q;
   logic [1:0]  off_q;
   logic        kill_q;
   logic [31:0] rd_shift;
   logic [31:0] rd_ext;

   assign start = (state_q == S_IDLE) && is_LS[3] && !lsu_flush;

   // Byte offset used for lane selection. Half and word accesses are
   // force-aligned. In the trap build a misaligned access never reaches
   // memory, so the forced value is harmless there too.
   // NOTE: every combinational output gets a default first so that no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      off_eff    = ls_addr[1:0];
      be_next    = 4'b1111;
      wdata_next = ls_wdata;
      case (is_LS[1:0])
         SZ_BYTE: begin
            be_next    = 4'b0001 << ls_addr[1:0];
            wdata_next = {4{ls_wdata[7:0]}};
         end
         SZ_HALF: begin
            off_eff    = {ls_addr[1], 1'b0};
            be_next    = 4'b0011 << {ls_addr[1], 1'b0};
            wdata_next = {2{ls_wdata[15:0]}};
         end
         default: off_eff = 2'b00;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      case (is_LS[1:0])
         SZ_BYTE: acc_misalign = 1'b0;
         SZ_HALF: acc_misalign = ls_addr[0];
         default: acc_misalign = |ls_addr[1:0];
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)      lsu_misalign <= 1'b0;
      else if (start) lsu_misalign <= acc_misalign;
   end
`else
   assign acc_misalign = 1'b0;
   assign lsu_misalign = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = acc_misalign ? S_DONE : S_REQ;
         S_REQ: begin
            if (dmem_gnt) begin
               // A granted access cannot be cancelled. A flushed store simply
               // skips its completion pulse. A flushed load still drains its
               // response.
               if (dmem_we) state_d = lsu_flush ? S_IDLE : S_DONE;
               else         state_d = S_RESP;
            end else if (lsu_flush) begin
               state_d = S_IDLE;
            end
         end
         S_RESP: if (dmem_rvld) state_d = (kill_q || lsu_flush) ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      lsu_busy = start || (state_q == S_REQ) || (state_q == S_RESP);
      lsu_done = (state_q == S_DONE) && !lsu_flush;
   end

   // Load extraction: move the addressed lane down to bit 0, then extend.
   always_comb begin
      rd_shift = dmem_rdata >> {off_q, 3'b000};
      case (size_q)
         SZ_BYTE: rd_ext = {{24{sign_q & rd_shift[7]}},  rd_shift[7:0]};
         SZ_HALF: rd_ext = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   // ---------------- request / datapath registers ----------------
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         size_q     <= '0;
         sign_q     <= 1'b0;
         off_q      <= '0;
         kill_q     <= 1'b0;
         lsu_rdata  <= '0;
      end else begin
         // Request is high exactly while in REQ, registered off the next state.
         dmem_req <= (state_d == S_REQ);
         if (start) begin
            dmem_we    <= is_LS[2];
            dmem_addr  <= {ls_addr[31:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
            size_q     <= is_LS[1:0];
            sign_q     <= dec_lsign;
            off_q      <= off_eff;
            kill_q     <= 1'b0;
         end else if (lsu_flush && ((state_q == S_REQ) || (state_q == S_RESP))) begin
            // Remembers a flush seen while a granted load is still draining.
            kill_q <= 1'b1;
         end
         if ((state_q == S_RESP) && dmem_rvld && !kill_q && !lsu_flush)
            lsu_rdata <= rd_ext;
      end
   end

endmodule
